csr_writeback: RTL and testbench

CSR_WRITEBACK -- requirements
Module: csr_writeback

---
 rtl/csr_writeback_pkg.sv | 33 +++
 rtl/csr_writeback.sv | 107 ++++++++++
 tb/tb_csr_writeback.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_writeback_pkg.sv
// csr_writeback_pkg: shared exception codes, FSM encodings and stage records for csr_writeback
package csr_writeback_pkg;
    localparam int EXCEPTION_W = 6;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ILLEGAL_INSTRUCTION = 6'h12;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_BREAKPOINT          = 6'h13;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ECALL               = 6'h18;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_ERET_U              = 6'h1c;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_INTERRUPT           = 6'h20;
    localparam logic [EXCEPTION_W-1:0] EXCEPTION_FENCE               = 6'h30;
    localparam logic [0:0] STATE_RUN    = 1'b0;
    localparam logic [0:0] STATE_SQUASH = 1'b1;
    typedef struct packed {
        logic                   valid;
        logic [31:0]            pc;
        logic [11:0]            csr_addr;
        logic [4:0]             rd_idx;
        logic [31:0]            value;
        logic                   write;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exc;
    } e2_t;
    typedef struct packed {
        logic                   valid;
        logic                   write;
        logic [11:0]            waddr;
        logic [31:0]            wdata;
        logic [EXCEPTION_W-1:0] exc;
        logic [31:0]            epc;
        logic                   rd_valid;
        logic [4:0]             rd_idx;
        logic [31:0]            rd_value;
    } wb_t;
endpackage

// File: rtl/csr_writeback.sv
// csr_writeback: two-stage (E2, WB) retirement of CSR results with trap/interrupt squash
// Ports: clk_i, rstn_i (async, active-low); E1 instruction + CSR result inputs;
// stall_i, take_interrupt_i, flush_i controls; CSR write, exception and GPR writeback
// outputs (all registered, single-cycle pulses); interrupt_inhibit_o.
// Optional: define CSR_WB_TVAL_EN to report the faulting opcode on exception_addr_o
// for illegal-instruction traps; otherwise exception_addr_o is tied to zero.
module csr_writeback
    import csr_writeback_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   valid_e1_i,
    input  logic [31:0]            pc_e1_i,
    input  logic [31:0]            opcode_e1_i,
    input  logic [4:0]             rd_idx_e1_i,
    input  logic [31:0]            csr_result_e1_value_i,
    input  logic                   csr_result_e1_write_i,
    input  logic [31:0]            csr_result_e1_wdata_i,
    input  logic [EXCEPTION_W-1:0] csr_result_e1_exception_i,
    input  logic                   stall_i,
    input  logic                   take_interrupt_i,
    input  logic                   flush_i,
    output logic                   csr_writeback_write_o,
    output logic [11:0]            csr_writeback_waddr_o,
    output logic [31:0]            csr_writeback_wdata_o,
    output logic [EXCEPTION_W-1:0] csr_writeback_exception_o,
    output logic [31:0]            csr_writeback_exception_pc_o,
    output logic [31:0]            csr_writeback_exception_addr_o,
    output logic                   rd_wb_valid_o,
    output logic [4:0]             rd_wb_idx_o,
    output logic [31:0]            rd_wb_value_o,
    output logic                   interrupt_inhibit_o
);
    logic [0:0]             state_q, state_d;
    e2_t                    e1_in, e2_q, e2_d;
    wb_t                    wb_q, wb_d;
    logic                   wb_trap, drop, retire, take_irq, no_exc, wr;
    logic [EXCEPTION_W-1:0] exc_e2;
    logic                   unused_opcode_low;

    assign unused_opcode_low = ^opcode_e1_i[19:0];

    // A trap leaving WB redirects the core, so everything younger is dead on that same edge.
    assign wb_trap  = wb_q.exc != '0;
    assign drop     = flush_i | (state_q == STATE_SQUASH) | wb_trap;
    assign retire   = e2_q.valid & ~drop & ~stall_i;
    assign take_irq = take_interrupt_i & e2_q.valid & (e2_q.exc == '0);
    assign exc_e2   = take_irq ? EXCEPTION_INTERRUPT : e2_q.exc;
    assign no_exc   = exc_e2 == '0;
    assign wr       = retire & no_exc & e2_q.write;

    assign e1_in = '{valid: 1'b1, pc: pc_e1_i, csr_addr: opcode_e1_i[31:20], rd_idx: rd_idx_e1_i,
                     value: csr_result_e1_value_i, write: csr_result_e1_write_i,
                     wdata: csr_result_e1_wdata_i, exc: csr_result_e1_exception_i};

    assign e2_d = drop ? '0 : stall_i ? e2_q : valid_e1_i ? e1_in : '0;

    // WB fields are stored already gated so every output is zero unless its own qualifier is set.
    always_comb begin
        wb_d          = '0;
        wb_d.valid    = retire;
        wb_d.write    = wr;
        wb_d.waddr    = wr ? e2_q.csr_addr : '0;
        wb_d.wdata    = wr ? e2_q.wdata : '0;
        wb_d.exc      = retire ? exc_e2 : '0;
        wb_d.epc      = (retire & ~no_exc) ? e2_q.pc : '0;
        wb_d.rd_valid = wr & (e2_q.rd_idx != '0);
        wb_d.rd_idx   = (wr & (e2_q.rd_idx != '0)) ? e2_q.rd_idx : '0;
        wb_d.rd_value = (wr & (e2_q.rd_idx != '0)) ? e2_q.value : '0;
    end

    assign state_d = (state_q == STATE_RUN) ? (wb_trap ? STATE_SQUASH : STATE_RUN)
                                            : (flush_i ? STATE_RUN : STATE_SQUASH);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= STATE_RUN;
            e2_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            e2_q    <= e2_d;
            wb_q    <= wb_d;
        end
    end

`ifdef CSR_WB_TVAL_EN
    logic [31:0] tval_q;
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) tval_q <= '0;
        else tval_q <= (retire && exc_e2 == EXCEPTION_ILLEGAL_INSTRUCTION) ? e2_q.value : '0;
    end
    assign csr_writeback_exception_addr_o = tval_q;
`else
    assign csr_writeback_exception_addr_o = '0;
`endif

    assign csr_writeback_write_o        = wb_q.write;
    assign csr_writeback_waddr_o        = wb_q.waddr;
    assign csr_writeback_wdata_o        = wb_q.wdata;
    assign csr_writeback_exception_o    = wb_q.exc;
    assign csr_writeback_exception_pc_o = wb_q.epc;
    assign rd_wb_valid_o                = wb_q.rd_valid;
    assign rd_wb_idx_o                  = wb_q.rd_idx;
    assign rd_wb_value_o                = wb_q.rd_value;
    assign interrupt_inhibit_o          = e2_q.valid | wb_q.valid | (state_q == STATE_SQUASH);
endmodule

// File: tb/tb_csr_writeback.sv
// tb_csr_writeback: randomized scoreboard bench for csr_writeback against an instruction-fate model
module tb_csr_writeback;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_e1 = 1'b0;
    logic [31:0] pc_e1 = '0, opcode_e1 = '0, value_e1 = '0, wdata_e1 = '0;
    logic [4:0]  rd_e1 = '0;
    logic        write_e1 = 1'b0;
    logic [5:0]  exc_e1 = '0;
    logic        stall = 1'b0, irq = 1'b0, flush = 1'b0;
    logic        wr_o, rdv_o, inh_o;
    logic [11:0] waddr_o;
    logic [31:0] wdata_o, epc_o, eaddr_o, rdval_o;
    logic [5:0]  exc_o;
    logic [4:0]  rdi_o;

`ifdef CSR_WB_TVAL_EN
    localparam bit TVAL = 1'b1;
`else
    localparam bit TVAL = 1'b0;
`endif

    csr_writeback dut (
        .clk_i(clk), .rstn_i(rstn),
        .valid_e1_i(valid_e1), .pc_e1_i(pc_e1), .opcode_e1_i(opcode_e1), .rd_idx_e1_i(rd_e1),
        .csr_result_e1_value_i(value_e1), .csr_result_e1_write_i(write_e1),
        .csr_result_e1_wdata_i(wdata_e1), .csr_result_e1_exception_i(exc_e1),
        .stall_i(stall), .take_interrupt_i(irq), .flush_i(flush),
        .csr_writeback_write_o(wr_o), .csr_writeback_waddr_o(waddr_o),
        .csr_writeback_wdata_o(wdata_o), .csr_writeback_exception_o(exc_o),
        .csr_writeback_exception_pc_o(epc_o), .csr_writeback_exception_addr_o(eaddr_o),
        .rd_wb_valid_o(rdv_o), .rd_wb_idx_o(rdi_o), .rd_wb_value_o(rdval_o),
        .interrupt_inhibit_o(inh_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, op, val, wd;
        logic [4:0]  rd;
        logic        w;
        logic [5:0]  exc;
    } instr_t;

    typedef struct packed {
        int          stamp;
        logic        write;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [5:0]  exc;
        logic [31:0] epc, eaddr;
        logic        rdv;
        logic [4:0]  rdi;
        logic [31:0] rdval;
    } exp_t;

    exp_t   exp_q[$];
    int     inh_q[$];
    int     edge_n = 0;
    int     checks = 0, failures = 0;
    bit     done = 1'b0;

    bit     m_e2_v, m_wb_busy, m_wb_trap, m_squash;
    instr_t m_e2;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic instr_t mk(logic [31:0] pc, logic [31:0] op, logic [4:0] rd, logic [31:0] val,
                                  logic w, logic [31:0] wd, logic [5:0] exc);
        instr_t i;
        i.pc = pc; i.op = op; i.rd = rd; i.val = val; i.w = w; i.wd = wd; i.exc = exc;
        return i;
    endfunction

    // What the retirement of one instruction must look like, straight from the architectural rules.
    function automatic exp_t predict(instr_t i, bit take_irq);
        exp_t e = '0;
        logic [5:0] c = (take_irq && i.exc == 6'h0) ? 6'h20 : i.exc;
        if (c != 6'h0) begin
            e.exc   = c;
            e.epc   = i.pc;
            e.eaddr = (TVAL && c == 6'h12) ? i.val : 32'h0;
        end else if (i.w) begin
            e.write = 1'b1;
            e.waddr = i.op[31:20];
            e.wdata = i.wd;
            if (i.rd != 5'd0) begin
                e.rdv   = 1'b1;
                e.rdi   = i.rd;
                e.rdval = i.val;
            end
        end
        return e;
    endfunction

    function automatic logic [152:0] pack(exp_t e);
        return {e.write, e.waddr, e.wdata, e.exc, e.epc, e.eaddr, e.rdv, e.rdi, e.rdval};
    endfunction

    task automatic model_reset();
        m_e2_v = 0; m_wb_busy = 0; m_wb_trap = 0; m_squash = 0; m_e2 = '0;
        exp_q.delete();
        inh_q.delete();
    endtask

    // One cycle: drive E1/controls, then decide the fate of the instruction waiting in E2.
    task automatic step(input bit v, input instr_t i, input bit st, input bit ir, input bit fl);
        int   k;
        bit   kill, ret, nsq;
        exp_t e;
        @(posedge clk);
        #1;
        k = edge_n;
        valid_e1 = v; pc_e1 = i.pc; opcode_e1 = i.op; rd_e1 = i.rd; value_e1 = i.val;
        write_e1 = i.w; wdata_e1 = i.wd; exc_e1 = i.exc; stall = st; irq = ir; flush = fl;
        kill = fl || m_squash || m_wb_trap;
        ret  = m_e2_v && !kill && !st;
        nsq  = m_squash ? !fl : m_wb_trap;
        e    = '0;
        if (ret) begin
            e = predict(m_e2, ir);
            e.stamp = k + 1;
            exp_q.push_back(e);
        end
        m_wb_busy = ret;
        m_wb_trap = ret && e.exc != 6'h0;
        m_squash  = nsq;
        if (kill) m_e2_v = 0;
        else if (!st) begin
            m_e2_v = v;
            m_e2   = i;
        end
        if (m_e2_v || m_wb_busy || m_squash) inh_q.push_back(k + 1);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(0, '0, 0, 0, 0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        valid_e1 = 0; stall = 0; irq = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin : monitor
        exp_t        want_e;
        logic [152:0] got, want;
        bit          want_inh;
        while (!done) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].stamp < edge_n) begin
                checks++;
                failures++;
                $display("FAIL stale_expect cycle=%0d stamp=%0d", edge_n, exp_q[0].stamp);
                void'(exp_q.pop_front());
            end
            while (inh_q.size() != 0 && inh_q[0] < edge_n) void'(inh_q.pop_front());
            want_e = '0;
            if (exp_q.size() != 0 && exp_q[0].stamp == edge_n) want_e = exp_q.pop_front();
            want = pack(want_e);
            got  = {wr_o, waddr_o, wdata_o, exc_o, epc_o, eaddr_o, rdv_o, rdi_o, rdval_o};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL outputs cycle=%0d got=%h want=%h", edge_n, got, want);
            end
            want_inh = 0;
            if (inh_q.size() != 0 && inh_q[0] == edge_n) begin
                want_inh = 1;
                void'(inh_q.pop_front());
            end
            checks++;
            if (inh_o !== want_inh) begin
                failures++;
                $display("FAIL inhibit cycle=%0d got=%b want=%b", edge_n, inh_o, want_inh);
            end
        end
    end

    initial begin : driver
        logic [5:0] codes[6];
        instr_t     r;
        codes = '{6'h12, 6'h13, 6'h18, 6'h1c, 6'h1b, 6'h30};
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        // csrrw mscratch
        step(1, mk(32'h8000_0000, 32'h3402_9073, 5'd5, 32'h0000_1111, 1, 32'hA5A5_A5A5, 6'h0), 0, 0, 0);
        idle(3);
        // illegal instruction, two followers dropped, then redirect
        step(1, mk(32'h8000_0100, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, 1, 32'h1, 6'h12), 0, 0, 0);
        step(1, mk(32'h8000_0104, 32'h3002_22F3, 5'd3, 32'h2, 1, 32'h3, 6'h0), 0, 0, 0);
        step(1, mk(32'h8000_0108, 32'h3002_22F3, 5'd4, 32'h4, 1, 32'h5, 6'h0), 0, 0, 0);
        idle(2);
        step(0, '0, 0, 0, 1);
        idle(2);
        // stall three cycles with E2 occupied; E1 traffic during stall ignored
        step(1, mk(32'h8000_0200, 32'h3412_9073, 5'd9, 32'h99, 1, 32'h77, 6'h0), 0, 0, 0);
        for (int j = 0; j < 3; j++)
            step(1, mk(32'h8000_0300, 32'h3402_9073, 5'd1, 32'h1, 1, 32'h1, 6'h0), 1, 0, 0);
        idle(3);
        // interrupt taken on a csrrs sitting in E2
        step(1, mk(32'h8000_0400, 32'h3002_22F3, 5'd5, 32'h1800, 1, 32'h1808, 6'h0), 0, 0, 0);
        step(0, '0, 0, 1, 0);
        idle(3);
        step(0, '0, 0, 0, 1);
        idle(2);
        // flush and stall together
        step(1, mk(32'h8000_0500, 32'h3402_9073, 5'd6, 32'h6, 1, 32'h6, 6'h0), 0, 0, 0);
        step(0, '0, 1, 0, 1);
        idle(3);
        // reset with E2 and WB occupied
        step(1, mk(32'h8000_0600, 32'h3402_9073, 5'd8, 32'h8, 1, 32'h8, 6'h0), 0, 0, 0);
        step(1, mk(32'h8000_0604, 32'h3412_9073, 5'd9, 32'h9, 1, 32'h9, 6'h0), 0, 0, 0);
        reset_pulse();
        idle(4);
        for (int n = 0; n < 3000; n++) begin
            r = mk($urandom, $urandom, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom, $urandom_range(0, 3) != 0, $urandom,
                   ($urandom_range(0, 7) == 0) ? codes[$urandom_range(0, 5)] : 6'h0);
            step($urandom_range(0, 3) != 0, r, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0);
            if (n == 1500) reset_pulse();
        end
        idle(4);
        step(0, '0, 0, 0, 1);
        idle(3);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        done = 1'b1;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
